// File: rtl/mem_arbiter_pkg.sv
// Types shared by the memory arbiter and its winner-selection logic.
`include "params.v"

package mem_arbiter_pkg;
   localparam int ADDR_W  = `ADDR_SIZE + 1;
   localparam int INSTR_W = `INSTR_SIZE + 1;

   typedef enum logic [2:0] {
      ST_IDLE    = `ARB_IDLE,
      ST_ISSUE_I = `ARB_ISSUE_I,
      ST_ISSUE_D = `ARB_ISSUE_D,
      ST_RESP_I  = `ARB_RESP_I,
      ST_RESP_D  = `ARB_RESP_D
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE  = 2'b00,
      GNT_FETCH = 2'b01,
      GNT_DATA  = 2'b10
   } grant_e;
endpackage

// File: rtl/arb_pick.sv
// Combinational IDLE-state winner selection with a bounded run of data grants
// while a fetch is waiting.
module arb_pick #(
   parameter int MAX_D_BURST = 4,
   parameter int CNT_W       = 3
) (
   input  logic             d_enable,
   input  logic             if_rd_enable,
   input  logic [CNT_W-1:0] burst_cnt,
   output logic             pick_d,
   output logic             pick_i,
   output logic [CNT_W-1:0] burst_cnt_next
);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_D_BURST);

   logic below_max;
   assign below_max = (burst_cnt < MAX_C);

   // Winner choice and next value of the consecutive-data-grant counter.
   always_comb begin
      pick_d         = 1'b0;
      pick_i         = 1'b0;
      burst_cnt_next = burst_cnt;
      if (d_enable && below_max) begin
         pick_d = 1'b1;
      end else if (if_rd_enable) begin
         pick_i = 1'b1;
      end else if (d_enable) begin
         pick_d = 1'b1;
      end else begin
         pick_d = 1'b0;
      end

      // Only a waiting fetch makes the run length matter.
      if (!if_rd_enable || pick_i) begin
         burst_cnt_next = {CNT_W{1'b0}};
      end else if (pick_d && below_max) begin
         burst_cnt_next = burst_cnt + CNT_W'(1);
      end else begin
         burst_cnt_next = burst_cnt;
      end
   end
endmodule

// File: rtl/params.v
// Shared widths and arbiter state encodings for the memory arbiter slice.
`ifndef MEM_ARB_PARAMS_V
`define MEM_ARB_PARAMS_V
`define ADDR_SIZE   31
`define INSTR_SIZE  31
`define ARB_IDLE    3'd0
`define ARB_ISSUE_I 3'd1
`define ARB_ISSUE_D 3'd2
`define ARB_RESP_I  3'd3
`define ARB_RESP_D  3'd4
`endif

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single-port
// memory with one outstanding transaction at a time.
`include "params.v"

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_D_BURST = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_rd_enable,
   input  logic [ADDR_W-1:0]  if_rd_addr,
   output logic [INSTR_W-1:0] if_rd_data,
   output logic               if_rd_ready,
   input  logic               flush,
   input  logic               d_enable,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [31:0]        d_wdata,
   input  logic [3:0]         d_wstrb,
   output logic [31:0]        d_rdata,
   output logic               d_ready,
   output logic               mem_enable,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [31:0]        mem_wdata,
   output logic [3:0]         mem_wstrb,
   input  logic [31:0]        mem_rdata,
   input  logic               mem_ready,
   output logic [1:0]         grant
);
   localparam int CNT_W = $clog2(MAX_D_BURST + 1);

   arb_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               kill_q;
   logic               pick_d;
   logic               pick_i;
   logic               mem_enable_q;
   logic               mem_we_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [31:0]        mem_wdata_q;
   logic [3:0]         mem_wstrb_q;
   logic [INSTR_W-1:0] if_rd_data_q;
   logic               if_rd_ready_q;
   logic [31:0]        d_rdata_q;
   logic               d_ready_q;
   grant_e             grant_q;

   arb_pick #(
      .MAX_D_BURST (MAX_D_BURST),
      .CNT_W       (CNT_W)
   ) u_pick (
      .d_enable       (d_enable),
      .if_rd_enable   (if_rd_enable),
      .burst_cnt      (cnt_q),
      .pick_d         (pick_d),
      .pick_i         (pick_i),
      .burst_cnt_next (cnt_d)
   );

   // Arbiter FSM: grant, memory request registers, read capture and ready pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= {CNT_W{1'b0}};
         kill_q        <= 1'b0;
         mem_enable_q  <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= {ADDR_W{1'b0}};
         mem_wdata_q   <= 32'h0000_0000;
         mem_wstrb_q   <= 4'h0;
         if_rd_data_q  <= {INSTR_W{1'b0}};
         if_rd_ready_q <= 1'b0;
         d_rdata_q     <= 32'h0000_0000;
         d_ready_q     <= 1'b0;
         grant_q       <= GNT_NONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               kill_q        <= 1'b0;
               if_rd_ready_q <= 1'b0;
               d_ready_q     <= 1'b0;
               cnt_q         <= cnt_d;
               if (pick_d) begin
                  state_q      <= ST_ISSUE_D;
                  grant_q      <= GNT_DATA;
                  mem_enable_q <= 1'b1;
                  mem_we_q     <= d_we;
                  mem_addr_q   <= d_addr;
                  mem_wdata_q  <= d_wdata;
                  mem_wstrb_q  <= d_wstrb;
               end else if (pick_i) begin
                  state_q      <= ST_ISSUE_I;
                  grant_q      <= GNT_FETCH;
                  mem_enable_q <= 1'b1;
                  mem_we_q     <= 1'b0;
                  mem_addr_q   <= if_rd_addr;
                  mem_wdata_q  <= 32'h0000_0000;
                  mem_wstrb_q  <= 4'h0;
               end else begin
                  state_q <= ST_IDLE;
                  grant_q <= GNT_NONE;
               end
            end
            ST_ISSUE_I: begin
               // A flushed fetch still runs to completion on the memory side.
               if (mem_ready) begin
                  mem_enable_q <= 1'b0;
                  state_q      <= ST_RESP_I;
                  if (kill_q || flush) begin
                     kill_q <= 1'b1;
                  end else begin
                     if_rd_data_q  <= mem_rdata;
                     if_rd_ready_q <= 1'b1;
                  end
               end else if (flush) begin
                  kill_q <= 1'b1;
               end
            end
            ST_ISSUE_D: begin
               if (mem_ready) begin
                  mem_enable_q <= 1'b0;
                  d_ready_q    <= 1'b1;
                  state_q      <= ST_RESP_D;
                  if (!mem_we_q) begin
                     d_rdata_q <= mem_rdata;
                  end
               end
            end
            ST_RESP_I: begin
               if_rd_ready_q <= 1'b0;
               kill_q        <= 1'b0;
               grant_q       <= GNT_NONE;
               state_q       <= ST_IDLE;
            end
            ST_RESP_D: begin
               d_ready_q <= 1'b0;
               kill_q    <= 1'b0;
               grant_q   <= GNT_NONE;
               state_q   <= ST_IDLE;
            end
            default: begin
               state_q       <= ST_IDLE;
               kill_q        <= 1'b0;
               mem_enable_q  <= 1'b0;
               if_rd_ready_q <= 1'b0;
               d_ready_q     <= 1'b0;
               grant_q       <= GNT_NONE;
            end
         endcase
      end
   end

   assign if_rd_data  = if_rd_data_q;
   // A flush arriving in the response cycle still cancels the delivery.
   assign if_rd_ready = if_rd_ready_q & ~flush;
   assign d_rdata     = d_rdata_q;
   assign d_ready     = d_ready_q;
   assign mem_enable  = mem_enable_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_wstrb   = mem_wstrb_q;
   assign grant       = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed expectations checked cycle by cycle.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        if_rd_enable;
   logic [31:0] if_rd_addr;
   logic [31:0] if_rd_data;
   logic        if_rd_ready;
   logic        flush;
   logic        d_enable;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_enable;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [1:0]  grant;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MAX_D_BURST(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .if_rd_enable (if_rd_enable),
      .if_rd_addr   (if_rd_addr),
      .if_rd_data   (if_rd_data),
      .if_rd_ready  (if_rd_ready),
      .flush        (flush),
      .d_enable     (d_enable),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_wstrb      (d_wstrb),
      .d_rdata      (d_rdata),
      .d_ready      (d_ready),
      .mem_enable   (mem_enable),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .grant        (grant)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory returns data in the current cycle; the arbiter samples it at the next edge.
   task automatic mem_resp(input logic [31:0] data);
      mem_ready = 1'b1;
      mem_rdata = data;
      tick();
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
   endtask

   initial begin
      reset = 1'b1; if_rd_enable = 1'b0; if_rd_addr = 32'h0; flush = 1'b0;
      d_enable = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
      mem_rdata = 32'h0; mem_ready = 1'b0;
      tick(); tick();
      chk("rst_mem_enable", 32'(mem_enable), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_if_rd_ready", 32'(if_rd_ready), 32'h0);
      chk("rst_d_ready", 32'(d_ready), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk("rst_if_rd_data", if_rd_data, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      reset = 1'b0;

      // Lone fetch, minimum latency
      if_rd_enable = 1'b1; if_rd_addr = 32'h100;
      chk("fetch_idle_grant", 32'(grant), 32'h0);
      tick();
      chk("fetch_mem_enable", 32'(mem_enable), 32'h1);
      chk("fetch_mem_addr", mem_addr, 32'h100);
      chk("fetch_mem_we", 32'(mem_we), 32'h0);
      chk("fetch_mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk("fetch_grant", 32'(grant), 32'h1);
      mem_resp(32'h0000_0013);
      chk("fetch_ready", 32'(if_rd_ready), 32'h1);
      chk("fetch_data", if_rd_data, 32'h0000_0013);
      chk("fetch_resp_mem_enable", 32'(mem_enable), 32'h0);
      chk("fetch_resp_grant", 32'(grant), 32'h1);
      if_rd_enable = 1'b0;
      tick();
      chk("fetch_ready_pulse", 32'(if_rd_ready), 32'h0);
      chk("fetch_back_idle", 32'(grant), 32'h0);

      // Stray mem_ready in IDLE is ignored
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ready = 1'b0; mem_rdata = 32'h0;
      chk("stray_grant", 32'(grant), 32'h0);
      chk("stray_if_rd_ready", 32'(if_rd_ready), 32'h0);
      chk("stray_d_ready", 32'(d_ready), 32'h0);
      chk("stray_if_rd_data", if_rd_data, 32'h0000_0013);

      // Fetch and load together: data first, then fetch
      if_rd_enable = 1'b1; if_rd_addr = 32'h104;
      d_enable = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      tick();
      chk("prio_data_first", 32'(grant), 32'h2);
      chk("prio_data_addr", mem_addr, 32'h300);
      mem_resp(32'hCAFE_0001);
      chk("prio_d_ready", 32'(d_ready), 32'h1);
      chk("prio_d_rdata", d_rdata, 32'hCAFE_0001);
      d_enable = 1'b0;
      tick();
      chk("prio_idle", 32'(grant), 32'h0);
      tick();
      chk("prio_fetch_next", 32'(grant), 32'h1);
      chk("prio_fetch_addr", mem_addr, 32'h104);
      mem_resp(32'h0000_0033);
      chk("prio_fetch_ready", 32'(if_rd_ready), 32'h1);
      chk("prio_d_rdata_held", d_rdata, 32'hCAFE_0001);
      if_rd_enable = 1'b0;
      tick();

      // Data burst limit with a waiting fetch
      if_rd_enable = 1'b1; if_rd_addr = 32'h108;
      d_enable = 1'b1; d_addr = 32'h400;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("burst_data_grant", 32'(grant), 32'h2);
         mem_resp(32'h0000_00B0 + 32'(i));
         tick();
      end
      tick();
      chk("burst_fetch_grant", 32'(grant), 32'h1);
      chk("burst_fetch_addr", mem_addr, 32'h108);
      mem_resp(32'h0000_0044);
      chk("burst_fetch_ready", 32'(if_rd_ready), 32'h1);
      chk("burst_d_rdata_last", d_rdata, 32'h0000_00B3);
      tick();
      tick();
      chk("burst_data_resume", 32'(grant), 32'h2);
      mem_resp(32'h0000_00D5);
      chk("burst_resume_rdata", d_rdata, 32'h0000_00D5);
      d_enable = 1'b0; if_rd_enable = 1'b0;
      tick();

      // Store with a delayed memory response
      d_enable = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'h3;
      tick();
      chk("store_grant", 32'(grant), 32'h2);
      chk("store_mem_we", 32'(mem_we), 32'h1);
      chk("store_mem_wstrb", 32'(mem_wstrb), 32'h3);
      chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("store_mem_addr", mem_addr, 32'h200);
      tick();
      chk("store_hold_enable", 32'(mem_enable), 32'h1);
      chk("store_hold_we", 32'(mem_we), 32'h1);
      chk("store_hold_wstrb", 32'(mem_wstrb), 32'h3);
      mem_resp(32'h1234_5678);
      chk("store_d_ready", 32'(d_ready), 32'h1);
      chk("store_d_rdata_kept", d_rdata, 32'h0000_00D5);
      d_enable = 1'b0; d_we = 1'b0; d_wstrb = 4'h0; d_wdata = 32'h0;
      tick();
      chk("store_ready_pulse", 32'(d_ready), 32'h0);

      // Flush during ISSUE_I with slow memory
      if_rd_enable = 1'b1; if_rd_addr = 32'h500;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0; if_rd_addr = 32'h600;
      chk("flush_enable_held", 32'(mem_enable), 32'h1);
      chk("flush_addr_held", mem_addr, 32'h500);
      tick();
      chk("flush_enable_held2", 32'(mem_enable), 32'h1);
      mem_resp(32'h0000_0BAD);
      chk("flush_no_ready", 32'(if_rd_ready), 32'h0);
      chk("flush_data_kept", if_rd_data, 32'h0000_0044);
      chk("flush_mem_enable_drop", 32'(mem_enable), 32'h0);
      tick();
      chk("flush_idle", 32'(grant), 32'h0);
      tick();
      chk("flush_refetch_addr", mem_addr, 32'h600);
      mem_resp(32'h0000_0077);
      chk("flush_refetch_ready", 32'(if_rd_ready), 32'h1);
      chk("flush_refetch_data", if_rd_data, 32'h0000_0077);
      if_rd_enable = 1'b0;
      tick();

      // Flush in RESP_I masks that cycle's ready
      if_rd_enable = 1'b1; if_rd_addr = 32'h700;
      tick();
      mem_resp(32'h0000_0088);
      flush = 1'b1;
      #1;
      chk("flush_resp_masked", 32'(if_rd_ready), 32'h0);
      flush = 1'b0;
      #1;
      chk("flush_resp_unmasked", 32'(if_rd_ready), 32'h1);
      if_rd_enable = 1'b0;
      tick();

      // Reset during ISSUE_D, then retry
      d_enable = 1'b1; d_we = 1'b0; d_addr = 32'h900;
      tick();
      chk("rstmid_enable", 32'(mem_enable), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstmid_mem_enable", 32'(mem_enable), 32'h0);
      chk("rstmid_grant", 32'(grant), 32'h0);
      chk("rstmid_d_ready", 32'(d_ready), 32'h0);
      chk("rstmid_d_rdata", d_rdata, 32'h0);
      tick();
      chk("rstmid_retry_grant", 32'(grant), 32'h2);
      mem_resp(32'h0000_0099);
      chk("rstmid_retry_ready", 32'(d_ready), 32'h1);
      chk("rstmid_retry_data", d_rdata, 32'h0000_0099);
      d_enable = 1'b0;
      tick();
      chk("rstmid_final_idle", 32'(grant), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_BURST, default 4: consecutive data grants allowed while a fetch waits.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_rd_enable  input  1  fetch read request, held until if_rd_ready.
REQ-005 SHALL have port if_rd_addr  input  `ADDR_SIZE+1  fetch address, stable while requesting.
REQ-006 SHALL have port if_rd_data  output  `INSTR_SIZE+1  instruction returned to fetch.
REQ-007 SHALL have port if_rd_ready  output  1  one-cycle completion pulse to fetch.
REQ-008 SHALL have port flush  input  1  cancels the outstanding fetch.
REQ-009 SHALL have port d_enable  input  1  data request, held until d_ready.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have ports d_addr  input  `ADDR_SIZE+1;  d_wdata  input  32;  d_wstrb  input  4 (byte enables).
REQ-012 SHALL have ports d_rdata  output  32 (load data);  d_ready  output  1 (one-cycle completion pulse).
REQ-013 SHALL have ports mem_enable, mem_we  output  1;  mem_addr  output  `ADDR_SIZE+1;  mem_wdata  output  32;  mem_wstrb  output  4.
REQ-014 SHALL have ports mem_rdata  input  32;  mem_ready  input  1 (one-cycle completion pulse from memory).
REQ-015 SHALL have port grant  output  2  current owner: 00 none, 01 fetch, 10 data.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE_I, ISSUE_D, RESP_I, RESP_D.
REQ-017 IDLE: d_enable and burst count < MAX_D_BURST -> ISSUE_D; else if_rd_enable -> ISSUE_I; else if d_enable -> ISSUE_D; else stay.
REQ-018 SHALL count consecutive data grants while if_rd_enable is high, saturating at MAX_D_BURST; count clears on any fetch grant or when if_rd_enable is low in IDLE.
REQ-019 ISSUE_x: mem_enable=1 with winner's addr/we/wdata/wstrb registered at grant; fetch issues mem_we=0, mem_wstrb=0; signals held stable until mem_ready.
REQ-020 ISSUE_x with mem_ready=1: capture mem_rdata into if_rd_data (ISSUE_I) or d_rdata (ISSUE_D), drop mem_enable, -> RESP_x.
REQ-021 RESP_x: pulse corresponding ready for exactly one cycle, ignore both requests, -> IDLE.
REQ-022 Minimum latency: request seen in IDLE at cycle N -> mem_enable at N+1 -> ready at N+2 when mem_ready is returned at N+1.
REQ-023 if_rd_data and d_rdata SHALL hold last captured value until next capture; stores leave d_rdata unchanged.
REQ-024 flush during ISSUE_I SHALL set a kill flag: memory transaction completes normally, but if_rd_ready is not pulsed and if_rd_data is not updated.
REQ-025 flush during RESP_I SHALL suppress that cycle's if_rd_ready; flush in any other state has no effect on data transactions.
REQ-026 Kill flag SHALL clear on entry to IDLE.
REQ-027 grant SHALL be 01 in ISSUE_I/RESP_I, 10 in ISSUE_D/RESP_D, 00 in IDLE.
REQ-028 mem_ready outside ISSUE_x SHALL be ignored.

Reset
REQ-029 reset SHALL force IDLE, count=0, kill=0 on the next edge, including mid-transaction; no ready pulse for the aborted transaction.
REQ-030 Reset values: mem_enable, mem_we, if_rd_ready, d_ready = 0; mem_addr, mem_wdata, mem_wstrb, if_rd_data, d_rdata = 0; grant = 00.

Structure
REQ-031 `ADDR_SIZE, `INSTR_SIZE and `ARB_IDLE/`ARB_ISSUE_I/`ARB_ISSUE_D/`ARB_RESP_I/`ARB_RESP_D encodings SHALL live in the shared params.v.
REQ-032 The IDLE winner selection (REQ-017/018) SHALL be a combinational sub-module arb_pick; all other logic stays in mem_arbiter.

Verification
REQ-033 Lone fetch addr 0x100, memory returns 0x00000013 one cycle after mem_enable -> if_rd_ready pulse at cycle N+2, if_rd_data=0x00000013, grant 01 then 00.
REQ-034 Fetch and load both requesting from IDLE -> data issued first, fetch issued in the IDLE immediately after RESP_D.
REQ-035 Fetch held high, data re-requesting continuously, MAX_D_BURST=4 -> exactly 4 data grants, then one fetch grant, then data resumes.
REQ-036 Store addr 0x200, wdata 0xDEADBEEF, wstrb 0x3 -> mem_we=1, mem_wstrb=0x3 held until mem_ready; d_ready pulses; d_rdata unchanged.
REQ-037 flush asserted while ISSUE_I with memory latency 3 -> mem_enable held until mem_ready, no if_rd_ready pulse, next fetch to flush target completes normally.
REQ-038 reset asserted during ISSUE_D -> next cycle mem_enable=0, grant=00, no d_ready pulse; subsequent request works.
